// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
// Holds the loader/receiver state encodings and the bit-period helper.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_DONE,
        ST_ERROR
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling, glitch and stop checks.
// flush drops any partially received frame and suppresses the output pulses.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       flush,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync1_q, sync2_q, prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // a start bit that has gone high again by mid-bit was noise
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
        if (flush) begin
            state_d = RX_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            ferr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_loader.sv
// Boot loader: parses A5 / len_lo / len_hi / data frames from the serial line and
// writes little-endian words to memory from address 0, holding the CPU until done.
module uart_loader
    import loader_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int NUM_OF_BYTES = 800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RxD,
    input  logic        reload,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_en,
    output logic        cpu_hold,
    output logic        busy,
    output logic        error
);

    localparam int CLKS_PER_BIT = int'(clks_per_bit(CLK_HZ, BAUD));

    logic       byte_valid, frame_err;
    logic [7:0] byte_data;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst_n      (reset),
        .rxd        (RxD),
        .flush      (reload),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    ld_state_e   state_q, state_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] n_q, n_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] data_q, data_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [15:0] n_new;

    assign n_new = {byte_data, len_lo_q};

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        n_d      = n_q;
        wcnt_d   = wcnt_q;
        lane_d   = lane_q;
        data_d   = data_q;
        addr_d   = addr_q;
        we_d     = 1'b0;

        // address advances the cycle after the strobe; DONE follows the last one
        if (we_q) begin
            addr_d = addr_q + 32'd4;
            wcnt_d = wcnt_q + 16'd1;
            if (wcnt_q + 16'd1 == n_q) state_d = ST_DONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (byte_valid && byte_data == HDR_BYTE) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (byte_valid) begin
                    len_lo_d = byte_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (byte_valid) begin
                    n_d    = n_new;
                    wcnt_d = '0;
                    lane_d = '0;
                    addr_d = '0;
                    if (n_new == 16'd0)
                        state_d = ST_DONE;
                    else if ({n_new, 2'b00} > 18'(NUM_OF_BYTES))
                        state_d = ST_ERROR;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (byte_valid) begin
                    data_d[lane_q*8 +: 8] = byte_data;
                    lane_d = lane_q + 2'd1;
                    we_d   = (lane_q == 2'd3);
                end
            end
            default: ;
        endcase

        if (frame_err && state_q != ST_DONE) state_d = ST_ERROR;

        if (reload) begin
            state_d  = ST_IDLE;
            len_lo_d = '0;
            n_d      = '0;
            wcnt_d   = '0;
            lane_d   = '0;
            data_d   = '0;
            addr_d   = '0;
            we_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            len_lo_q <= '0;
            n_q      <= '0;
            wcnt_q   <= '0;
            lane_q   <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            n_q      <= n_d;
            wcnt_q   <= wcnt_d;
            lane_q   <= lane_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
        end
    end

    assign mem_address    = addr_q;
    assign mem_write_data = data_q;
    assign mem_write_en   = we_q;
    assign cpu_hold       = (state_q != ST_DONE);
    assign busy           = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) || (state_q == ST_DATA);
    assign error          = (state_q == ST_ERROR);

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: serial images driven bit by bit, writes
// captured by a monitor and compared against hand-computed words.
module tb_uart_loader;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        RxD = 1'b1;
    logic        reload = 1'b0;
    logic [31:0] mem_address, mem_write_data;
    logic        mem_write_en, cpu_hold, busy, error;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_we_cyc = -100;
    int hold_fall_cyc = -1;
    logic hold_prev = 1'b1;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    uart_loader #(
        .CLK_HZ       (1_600_000),
        .BAUD         (100_000),
        .NUM_OF_BYTES (800)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .RxD            (RxD),
        .reload         (reload),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .cpu_hold       (cpu_hold),
        .busy           (busy),
        .error          (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_write_en) begin
            wa_q.push_back(mem_address);
            wd_q.push_back(mem_write_data);
            last_we_cyc = cyc;
        end
        if (hold_prev && !cpu_hold) hold_fall_cyc = cyc;
        hold_prev = cpu_hold;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        @(negedge clk);
        RxD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (CPB) @(negedge clk);
        end
        RxD = stop_bit;
        repeat (CPB) @(negedge clk);
        RxD = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        hold_fall_cyc = -1;
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_addr", mem_address, 32'd0);
        chk("rst_data", mem_write_data, 32'd0);
        chk("rst_we", 32'(mem_write_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // two-word image
        clear_log();
        send_byte(8'hA5);
        chk("t1_busy_hdr", 32'(busy), 32'd1);
        chk("t1_hold_hdr", 32'(cpu_hold), 32'd1);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        repeat (5) @(negedge clk);
        chk("t1_nwr", wa_q.size(), 32'd2);
        if (wa_q.size() == 2) begin
            chk("t1_a0", wa_q[0], 32'd0);
            chk("t1_d0", wd_q[0], 32'h12345678);
            chk("t1_a1", wa_q[1], 32'd4);
            chk("t1_d1", wd_q[1], 32'hDEADBEEF);
        end
        chk("t1_hold_lat", 32'(hold_fall_cyc - last_we_cyc), 32'd1);
        chk("t1_hold", 32'(cpu_hold), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_err", 32'(error), 32'd0);

        // bytes after DONE are ignored
        send_byte(8'hA5);
        chk("t1_done_ign", 32'(cpu_hold), 32'd0);

        // noise before header, zero-length image
        pulse_reload();
        chk("t2_hold_rl", 32'(cpu_hold), 32'd1);
        clear_log();
        send_byte(8'h00); send_byte(8'hFF);
        chk("t2_idle_busy", 32'(busy), 32'd0);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        chk("t2_nwr", wa_q.size(), 32'd0);
        chk("t2_hold", 32'(cpu_hold), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);

        // oversize image, then recovery
        pulse_reload();
        clear_log();
        send_byte(8'hA5); send_byte(8'hC9); send_byte(8'h00);
        chk("t3_err", 32'(error), 32'd1);
        chk("t3_hold", 32'(cpu_hold), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        chk("t3_sticky", 32'(error), 32'd1);
        chk("t3_nwr", wa_q.size(), 32'd0);
        pulse_reload();
        chk("t3_err_clr", 32'(error), 32'd0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        repeat (5) @(negedge clk);
        chk("t3_nwr2", wa_q.size(), 32'd1);
        if (wa_q.size() == 1) begin
            chk("t3_a0", wa_q[0], 32'd0);
            chk("t3_d0", wd_q[0], 32'h44332211);
        end
        chk("t3_hold2", 32'(cpu_hold), 32'd0);

        // quarter-bit glitch, then a good image
        pulse_reload();
        clear_log();
        RxD = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        RxD = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("t4_glitch_busy", 32'(busy), 32'd0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        repeat (5) @(negedge clk);
        chk("t4_nwr", wa_q.size(), 32'd1);
        if (wa_q.size() == 1) chk("t4_d0", wd_q[0], 32'hDDCCBBAA);
        chk("t4_hold", 32'(cpu_hold), 32'd0);

        // framing error on 3rd data byte
        pulse_reload();
        clear_log();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03, 1'b0);
        send_byte(8'h04);
        chk("t5_err", 32'(error), 32'd1);
        chk("t5_hold", 32'(cpu_hold), 32'd1);
        chk("t5_nwr", wa_q.size(), 32'd0);

        // boundary: N = 200 accepted
        pulse_reload();
        send_byte(8'hA5); send_byte(8'hC8); send_byte(8'h00);
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_err", 32'(error), 32'd0);

        // async reset mid-image, then resend
        pulse_reload();
        clear_log();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05);
        chk("t7_pre_addr", mem_address, 32'd4);
        RxD = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t7_hold", 32'(cpu_hold), 32'd1);
        chk("t7_addr", mem_address, 32'd0);
        chk("t7_data", mem_write_data, 32'd0);
        chk("t7_we", 32'(mem_write_en), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_err", 32'(error), 32'd0);
        RxD = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        clear_log();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        repeat (5) @(negedge clk);
        chk("t7_nwr", wa_q.size(), 32'd2);
        if (wa_q.size() == 2) begin
            chk("t7_d0", wd_q[0], 32'h12345678);
            chk("t7_a1", wa_q[1], 32'd4);
            chk("t7_d1", wd_q[1], 32'hDEADBEEF);
        end
        chk("t7_done", 32'(cpu_hold), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
